// File: rtl/dmem_if.sv
// Core data-port bundle: the core drives the request, the responder returns data, stall and fault.
interface dmem_if;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        err;

  modport master (output req, we, size, addr, wd, input rd, stall, err);
  modport slave  (input req, we, size, addr, wd, output rd, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory slave for the core load/store port: word RAM with byte lanes, fixed access
// latency enforced by stalling, RISC-V size/sign handling and access-fault reporting.
//
// state | meaning
// IDLE  | no access in flight; a request is latched and stall follows req
// WAIT  | latency countdown, core stalled; dropping req aborts the access
// DONE  | result/fault presented, stall released; a store commits on the exit edge
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input logic   clk_i,
  input logic   rst_i,
  dmem_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch_en;
  logic        stall;
  logic        lat_we_q;
  logic [2:0]  lat_size_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wd_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] widx;
  logic        in_range;
  logic        fault;
  logic [31:0] word;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Addresses below BASE_ADDR wrap to a large offset and so fall out of range too.
  assign off      = lat_addr_q - BASE_ADDR;
  assign widx     = off[AW+1:2];
  assign in_range = (off >> (AW + 2)) == 32'd0;
  assign word     = mem[widx];

  always_comb begin
    fault = 1'b0;
    case (lat_size_q)
      3'd0, 3'd4: fault = 1'b0;
      3'd1, 3'd5: fault = lat_addr_q[0];
      3'd2:       fault = lat_addr_q[1:0] != 2'b00;
      default:    fault = 1'b1;
    endcase
    if (lat_we_q && (lat_size_q == 3'd4 || lat_size_q == 3'd5)) fault = 1'b1;
    if (!in_range) fault = 1'b1;
  end

  always_comb begin
    lb       = word[8*lat_addr_q[1:0] +: 8];
    lh       = lat_addr_q[1] ? word[31:16] : word[15:0];
    load_val = '0;
    case (lat_size_q)
      3'd0:    load_val = {{24{lb[7]}}, lb};
      3'd4:    load_val = {24'd0, lb};
      3'd1:    load_val = {{16{lh[15]}}, lh};
      3'd5:    load_val = {16'd0, lh};
      3'd2:    load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = lat_wd_q;
    case (lat_size_q)
      3'd0: begin
        be    = 4'b0001 << lat_addr_q[1:0];
        wdata = {4{lat_wd_q[7:0]}};
      end
      3'd1: begin
        be    = lat_addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{lat_wd_q[15:0]}};
      end
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.req;
        if (bus.req) begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (!bus.req)           state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = DONE;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_we_q   <= 1'b0;
      lat_size_q <= '0;
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        lat_we_q   <= bus.we;
        lat_size_q <= bus.size;
        lat_addr_q <= bus.addr;
        lat_wd_q   <= bus.wd;
      end
      // Result and fault are registered on entry to DONE so the RAM read is synchronous.
      if (state_q == WAIT && state_d == DONE) begin
        rd_q  <= fault ? 32'd0 : load_val;
        err_q <= fault;
      end else begin
        rd_q  <= '0;
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && state_q == DONE && lat_we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.stall = stall & rst_i;
  assign bus.rd    = rd_q;
  assign bus.err   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory slave answering the core's load/store port: mem_req/mem_we/mem_addr/mem_size/mem_wd in, read data and stall back. Holds a word-organised RAM with byte-lane writes. Applies a configurable access latency by stalling the core, then performs RISC-V size and sign handling. Sits between the core's data port and the system bus, replacing the zero-latency data RAM.

Parameters:
DEPTH, 1024, RAM size in 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4*DEPTH aligned
LATENCY, 2, stall cycles per access; legal range 1..15

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous active-low reset
req_i  in  1  access request (core mem_req_o)
we_i  in  1  1 = store, 0 = load
size_i  in  3  funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
addr_i  in  32  byte address
wd_i  in  32  store data; lane 0 = wd_i[7:0]
rd_o  out  32  load result, sign/zero extended
stall_o  out  1  holds the core (core stall_i)
err_o  out  1  one-cycle access fault pulse

Behaviour:
- FSM states IDLE, WAIT, DONE. Down-counter cnt, 4 bits. Latched copies of we, size, addr, wd.
- Reset (rst_i=0 at an edge): state IDLE, cnt 0, latches 0, rd_o 0, err_o 0. No RAM write. stall_o forced 0 while rst_i=0. RAM contents are not reset.
- IDLE:
  - stall_o = req_i (combinational).
  - On req_i=1: latch request, cnt <= LATENCY-1, go to WAIT.
- WAIT:
  - stall_o = 1.
  - If req_i=0 (core trap/interrupt killed the access): abort to IDLE, no write, err_o 0.
  - Else if cnt==0: go to DONE.
  - Else cnt decrements.
- DONE:
  - stall_o = 0. rd_o valid this cycle. err_o asserted this cycle if faulted.
  - Store commits to RAM at the edge leaving DONE.
  - Always returns to IDLE. The core advances at the same edge, so the request is never re-accepted.
- Timing: the core sees stall_o high for exactly LATENCY+1 cycles (request cycle plus LATENCY WAIT cycles). Data is returned in cycle LATENCY+2 counted from the request cycle.
- Word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]. Byte offset = addr[1:0].
- Loads (rd_o is 0 outside DONE and on fault):
  - B: byte at offset, sign extended.
  - BU: byte at offset, zero extended.
  - H: halfword at offset[1], sign extended.
  - HU: halfword at offset[1], zero extended.
  - W: whole word.
- Stores use byte enables:
  - B: lane = offset, data wd[7:0].
  - H: lanes 2*offset[1]..+1, data wd[15:0].
  - W: all four lanes.
  - Unselected lanes are unchanged.
- Fault conditions, checked on the latched request:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - size 3, 6 or 7.
  - Store with size 4 or 5.
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
- On fault: no RAM write, rd_o 0, err_o=1 in DONE. Latency is unchanged.
- Signals outside the latched copies are ignored in WAIT/DONE. The core holds them stable while stalled.
- Reset in WAIT or DONE: the pending store is dropped and stall_o falls in the same cycle.

Test Plan:
- LATENCY=2, SW 0xDEADBEEF @0x10 → stall_o high for 3 cycles, no error. Then LW @0x10 → rd_o=0xDEADBEEF in DONE.
- From that state: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB wd=0x12345655 @0x11, then SH wd=0x0000AAAA @0x12, then LW @0x10 → 0xAAAA55EF.
- LW @0x12, SH @0x11, size=3, and LW @BASE+4*DEPTH → each gives err_o pulse in DONE, rd_o 0, RAM unchanged (LW @0x10 still 0xAAAA55EF).
- req_i dropped in the 2nd WAIT cycle of an SW 0x0 @0x10 → state IDLE next edge, stall_o 0, word still 0xAAAA55EF.
- rst_i=0 during WAIT of an SW @0x20 → stall_o 0 immediately, IDLE, word @0x20 unchanged. Sweep LATENCY=1 and 15 → stall lengths of 2 and 16 cycles.
